// File: rtl/branch_arb.sv
// branch_arb: two requesters share a single RV32I branch comparator.
// Each requester owns a one-entry result slot. A round-robin arbiter grants
// at most one request per cycle, and the comparator result is registered into
// the granted slot, so the response appears one cycle after the grant.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   reqN_valid/_a/_b/_op      requester N compare request (funct3 encoding)
//   reqN_ready                grant to requester N (combinational)
//   respN_valid/_taken/_illegal  result slot N contents
//   respN_ready               consumer N pops slot N
//   flush                     synchronous cancel of held and incoming work
//   taken_cnt                 saturating count of taken results since reset
module branch_arb #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [31:0]      req0_a,
  input  logic [31:0]      req0_b,
  input  logic [2:0]       req0_op,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [31:0]      req1_a,
  input  logic [31:0]      req1_b,
  input  logic [2:0]       req1_op,
  output logic             req1_ready,
  output logic             resp0_valid,
  output logic             resp0_taken,
  output logic             resp0_illegal,
  input  logic             resp0_ready,
  output logic             resp1_valid,
  output logic             resp1_taken,
  output logic             resp1_illegal,
  input  logic             resp1_ready,
  input  logic             flush,
  output logic [CNT_W-1:0] taken_cnt
);

  // Returns {illegal, taken}. Ops 010/011 are not branches.
  function automatic logic [1:0] br_eval(input logic [2:0]  op,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sa = a;
    sb = b;
    case (op)
      3'b000:  br_eval = {1'b0, a == b};
      3'b001:  br_eval = {1'b0, a != b};
      3'b100:  br_eval = {1'b0, sa < sb};
      3'b101:  br_eval = {1'b0, sa >= sb};
      3'b110:  br_eval = {1'b0, a < b};
      3'b111:  br_eval = {1'b0, a >= b};
      default: br_eval = 2'b10;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    sat_inc = (&v) ? v : v + CNT_W'(1);
  endfunction

  logic             full0_q, full0_d, full1_q, full1_d;
  logic             taken0_q, taken0_d, taken1_q, taken1_d;
  logic             ill0_q, ill0_d, ill1_q, ill1_d;
  logic             last_q, last_d;   // 1: requester 1 was granted last
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic        elig0, elig1, grant0, grant1;
  logic [2:0]  sel_op;
  logic [31:0] sel_a, sel_b;
  logic [1:0]  res;

  // A full slot can still accept when its consumer pops in the same cycle.
  assign elig0 = req0_valid & ~flush & (~full0_q | resp0_ready);
  assign elig1 = req1_valid & ~flush & (~full1_q | resp1_ready);

  // On a tie the requester not granted last wins.
  assign grant0 = elig0 & (~elig1 | last_q);
  assign grant1 = elig1 & (~elig0 | ~last_q);

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // The shared comparator only sees the granted requester's operands.
  assign sel_op = grant1 ? req1_op : req0_op;
  assign sel_a  = grant1 ? req1_a  : req0_a;
  assign sel_b  = grant1 ? req1_b  : req0_b;
  assign res    = br_eval(sel_op, sel_a, sel_b);

  always_comb begin
    full0_d  = full0_q;
    full1_d  = full1_q;
    taken0_d = taken0_q;
    taken1_d = taken1_q;
    ill0_d   = ill0_q;
    ill1_d   = ill1_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    if (flush) begin
      full0_d  = 1'b0;
      full1_d  = 1'b0;
      taken0_d = 1'b0;
      taken1_d = 1'b0;
      ill0_d   = 1'b0;
      ill1_d   = 1'b0;
    end else begin
      if (grant0) begin
        full0_d  = 1'b1;
        taken0_d = res[0];
        ill0_d   = res[1];
      end else if (resp0_ready) begin
        full0_d  = 1'b0;
      end
      if (grant1) begin
        full1_d  = 1'b1;
        taken1_d = res[0];
        ill1_d   = res[1];
      end else if (resp1_ready) begin
        full1_d  = 1'b0;
      end
      if (grant0 | grant1) begin
        last_d = grant1;
        if (res[0]) cnt_d = sat_inc(cnt_q);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full0_q  <= 1'b0;
      full1_q  <= 1'b0;
      taken0_q <= 1'b0;
      taken1_q <= 1'b0;
      ill0_q   <= 1'b0;
      ill1_q   <= 1'b0;
      last_q   <= 1'b1;
      cnt_q    <= '0;
    end else begin
      full0_q  <= full0_d;
      full1_q  <= full1_d;
      taken0_q <= taken0_d;
      taken1_q <= taken1_d;
      ill0_q   <= ill0_d;
      ill1_q   <= ill1_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
    end
  end

  assign resp0_valid   = full0_q;
  assign resp0_taken   = taken0_q;
  assign resp0_illegal = ill0_q;
  assign resp1_valid   = full1_q;
  assign resp1_taken   = taken1_q;
  assign resp1_illegal = ill1_q;
  assign taken_cnt     = cnt_q;

endmodule

// File: tb/tb_branch_arb.sv
module tb_branch_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]  req0_op, req1_op;
  logic        resp0_ready, resp1_ready, flush;

  logic        req0_ready, req1_ready;
  logic        resp0_valid, resp0_taken, resp0_illegal;
  logic        resp1_valid, resp1_taken, resp1_illegal;
  logic [15:0] taken_cnt;

  logic        s_req0_ready, s_req1_ready;
  logic        s_resp0_valid, s_resp0_taken, s_resp0_illegal;
  logic        s_resp1_valid, s_resp1_taken, s_resp1_illegal;
  logic [1:0]  s_taken_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  branch_arb #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .req1_ready(req1_ready),
    .resp0_valid(resp0_valid), .resp0_taken(resp0_taken), .resp0_illegal(resp0_illegal),
    .resp0_ready(resp0_ready),
    .resp1_valid(resp1_valid), .resp1_taken(resp1_taken), .resp1_illegal(resp1_illegal),
    .resp1_ready(resp1_ready),
    .flush(flush), .taken_cnt(taken_cnt)
  );

  // Narrow-counter instance sharing the same stimulus, for saturation.
  branch_arb #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req0_ready(s_req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .req1_ready(s_req1_ready),
    .resp0_valid(s_resp0_valid), .resp0_taken(s_resp0_taken), .resp0_illegal(s_resp0_illegal),
    .resp0_ready(resp0_ready),
    .resp1_valid(s_resp1_valid), .resp1_taken(s_resp1_taken), .resp1_illegal(s_resp1_illegal),
    .resp1_ready(resp1_ready),
    .flush(flush), .taken_cnt(s_taken_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst = 1'b0;
    req0_valid = 0; req0_a = 0; req0_b = 0; req0_op = 0;
    req1_valid = 0; req1_a = 0; req1_b = 0; req1_op = 0;
    resp0_ready = 0; resp1_ready = 0; flush = 0;
    #1 rst = 1'b1;
    #1;
    chk("rst_resp0_valid", resp0_valid, 0);
    chk("rst_resp1_valid", resp1_valid, 0);
    chk("rst_taken_cnt", taken_cnt, 0);
    tick(); tick();
    rst = 1'b0;

    // blt -1 < 1 is taken
    req0_valid = 1; req0_op = 3'b100; req0_a = 32'hFFFF_FFFF; req0_b = 32'd1;
    resp0_ready = 1;
    settle();
    chk("blt_req0_ready", req0_ready, 1);
    chk("blt_req1_ready", req1_ready, 0);
    tick();
    req0_valid = 0; resp0_ready = 0;
    chk("blt_resp0_valid", resp0_valid, 1);
    chk("blt_resp0_taken", resp0_taken, 1);
    chk("blt_resp0_illegal", resp0_illegal, 0);
    chk("blt_taken_cnt", taken_cnt, 1);

    // Async reset while slot 0 is full: outputs clear before any edge
    tick();
    chk("hold_before_rst", resp0_valid, 1);
    rst = 1'b1;
    #1;
    chk("async_rst_valid", resp0_valid, 0);
    chk("async_rst_taken", resp0_taken, 0);
    chk("async_rst_cnt", taken_cnt, 0);
    tick();
    rst = 1'b0;

    // Round-robin: both valid, both consumers ready, starting with 0
    req0_valid = 1; req0_op = 3'b000; req0_a = 32'd7; req0_b = 32'd7;
    req1_valid = 1; req1_op = 3'b001; req1_a = 32'd1; req1_b = 32'd2;
    resp0_ready = 1; resp1_ready = 1;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("rr_req0_ready", req0_ready, (i % 2 == 0) ? 1 : 0);
      chk("rr_req1_ready", req1_ready, (i % 2 == 1) ? 1 : 0);
      tick();
      chk("rr_resp0_valid", resp0_valid, (i % 2 == 0) ? 1 : 0);
      chk("rr_resp1_valid", resp1_valid, (i % 2 == 1) ? 1 : 0);
    end
    chk("rr_taken_cnt", taken_cnt, 4);
    req0_valid = 0; req1_valid = 0;
    tick();
    chk("rr_drain0", resp0_valid, 0);
    chk("rr_drain1", resp1_valid, 0);

    // bltu 0xFFFFFFFF < 1 is not taken; slot held while consumer stalls
    req0_valid = 1; req0_op = 3'b110; req0_a = 32'hFFFF_FFFF; req0_b = 32'd1;
    resp0_ready = 0; resp1_ready = 0;
    settle();
    chk("bltu_req0_ready", req0_ready, 1);
    tick();
    chk("bltu_resp0_valid", resp0_valid, 1);
    chk("bltu_resp0_taken", resp0_taken, 0);
    req0_a = 32'd0;   // second request: 0 < 1 taken
    settle();
    chk("stall_req0_ready", req0_ready, 0);
    tick();
    chk("stall_resp0_valid", resp0_valid, 1);
    chk("stall_resp0_taken", resp0_taken, 0);
    chk("stall_cnt", taken_cnt, 4);
    resp0_ready = 1;
    settle();
    chk("pop_req0_ready", req0_ready, 1);
    tick();
    req0_valid = 0;
    chk("overwrite_valid", resp0_valid, 1);
    chk("overwrite_taken", resp0_taken, 1);
    chk("overwrite_cnt", taken_cnt, 5);
    tick();
    chk("overwrite_drain", resp0_valid, 0);

    // Illegal op 010 on requester 1
    req1_valid = 1; req1_op = 3'b010; req1_a = 32'd3; req1_b = 32'd3;
    resp1_ready = 1;
    settle();
    chk("ill_req1_ready", req1_ready, 1);
    tick();
    req1_valid = 0;
    chk("ill_resp1_valid", resp1_valid, 1);
    chk("ill_resp1_taken", resp1_taken, 0);
    chk("ill_resp1_illegal", resp1_illegal, 1);
    chk("ill_cnt", taken_cnt, 5);
    tick();
    chk("ill_drain", resp1_valid, 0);

    // Fill both slots, then flush
    resp0_ready = 0; resp1_ready = 0;
    req0_valid = 1; req0_op = 3'b101; req0_a = 32'd4; req0_b = 32'hFFFF_FFFE;
    req1_valid = 1; req1_op = 3'b111; req1_a = 32'd9; req1_b = 32'd9;
    settle();
    chk("fill_req0_first", req0_ready, 1);
    tick();
    settle();
    chk("fill_req1_second", req1_ready, 1);
    tick();
    chk("fill_both_valid", {resp0_valid, resp1_valid}, 2'b11);
    chk("fill_cnt", taken_cnt, 7);
    flush = 1; resp0_ready = 1; resp1_ready = 1;
    settle();
    chk("flush_readies", {req0_ready, req1_ready}, 2'b00);
    tick();
    flush = 0;
    chk("flush_valids", {resp0_valid, resp1_valid}, 2'b00);
    chk("flush_cnt", taken_cnt, 7);
    settle();
    chk("flush_ptr_kept", {req0_ready, req1_ready}, 2'b10);
    req0_valid = 0; req1_valid = 0;
    tick();

    // Saturation on the 2-bit instance
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req0_valid = 1; req0_op = 3'b000; req0_a = 32'd5; req0_b = 32'd5;
    resp0_ready = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("sat_cnt", s_taken_cnt, (i < 2) ? i + 1 : 3);
      chk("wide_cnt", taken_cnt, i + 1);
    end
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", resp0_valid, 0);
    chk("mid_rst_taken", resp0_taken, 0);
    chk("mid_rst_sat_cnt", s_taken_cnt, 0);
    chk("mid_rst_cnt", taken_cnt, 0);
    req0_valid = 0;
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_valid", resp0_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
